// File: rtl/sq_wave_pkg.sv
// Shared definitions for the Square_wave generator configuration path:
// divider width, disable code, step-index width and sweep sequencer states.
package sq_wave_pkg;

    localparam int SQW_DIV_W        = 16;
    localparam int SQW_DISABLE_CODE = 65535;
    localparam int SQW_STEP_IDX_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DWELL,
        ST_SHUTDOWN,
        ST_DONE
    } sweep_state_t;

endpackage

// File: rtl/square_wave_sweep_ctrl_if.sv
// Generator configuration channel: half-period divider offered under a valid/ready handshake.
interface square_wave_sweep_ctrl_if
    import sq_wave_pkg::*;
#(
    parameter int DIV_W = SQW_DIV_W
);

    logic [DIV_W-1:0] Cfg_Half_Div;
    logic             Cfg_Valid;
    logic             Cfg_Ready;

    modport master (
        output Cfg_Half_Div,
        output Cfg_Valid,
        input  Cfg_Ready
    );

    modport slave (
        input  Cfg_Half_Div,
        input  Cfg_Valid,
        output Cfg_Ready
    );

endinterface

// File: rtl/sweep_dwell_timer.sv
// Dwell counter for the sweep sequencer: counts 0..DURATION-1 while enabled and
// flags the last count so the sequencer can leave the dwell on that same edge.
module sweep_dwell_timer #(
    parameter int DURATION = 10000
) (
    input  logic Sys_Clock,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CNT_W = (DURATION > 1) ? $clog2(DURATION) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DURATION - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge Sys_Clock) begin
        if (Reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST_CNT) ? '0 : count + CNT_W'(1);
        end
    end

    assign tc = enable && (count == LAST_CNT);

endmodule

// File: rtl/square_wave_sweep_ctrl.sv
// Frequency-sweep sequencer: walks the generator's half-period divider from
// MAX_HALF_DIV down to MIN_HALF_DIV, dwelling on each, then parks it with DISABLE_CODE.
module square_wave_sweep_ctrl
    import sq_wave_pkg::*;
#(
    parameter int DURATION     = 10000,
    parameter int MAX_HALF_DIV = 5400,
    parameter int MIN_HALF_DIV = 54,
    parameter int DIV_STEP     = 54,
    parameter int DISABLE_CODE = SQW_DISABLE_CODE,
    parameter int DIV_W        = SQW_DIV_W
) (
    input  logic                          Sys_Clock,
    input  logic                          Reset,
    input  logic                          Start,
    input  logic                          Abort,
    square_wave_sweep_ctrl_if.master      cfg,
    output logic                          Sweep_Busy,
    output logic                          Sweep_Done,
    output logic [SQW_STEP_IDX_W-1:0]     Step_Index
);

    if (MIN_HALF_DIV > MAX_HALF_DIV) begin : g_chk_div_order
        $error("MIN_HALF_DIV must not exceed MAX_HALF_DIV");
    end
    if (DIV_STEP < 1) begin : g_chk_step
        $error("DIV_STEP must be at least 1");
    end
    if (DURATION < 1) begin : g_chk_duration
        $error("DURATION must be at least 1");
    end
    if (MAX_HALF_DIV == DISABLE_CODE) begin : g_chk_disable
        $error("MAX_HALF_DIV must differ from DISABLE_CODE");
    end

    localparam logic [DIV_W-1:0] MAX_D  = DIV_W'(MAX_HALF_DIV);
    localparam logic [DIV_W-1:0] MIN_D  = DIV_W'(MIN_HALF_DIV);
    localparam logic [DIV_W-1:0] STEP_D = DIV_W'(DIV_STEP);
    localparam logic [DIV_W-1:0] DIS_D  = DIV_W'(DISABLE_CODE);
    localparam logic [DIV_W:0]   MIN_X  = (DIV_W+1)'(MIN_HALF_DIV);
    localparam logic [DIV_W:0]   STEP_X = (DIV_W+1)'(DIV_STEP);

    sweep_state_t                state_q,    state_n;
    logic [DIV_W-1:0]            cur_div_q,  cur_div_n;
    logic [DIV_W-1:0]            half_div_q, half_div_n;
    logic                        valid_q,    valid_n;
    logic                        busy_q,     busy_n;
    logic                        done_q,     done_n;
    logic                        abort_q,    abort_n;
    logic [SQW_STEP_IDX_W-1:0]   step_q,     step_n;

    logic             transfer;
    logic             dwell_tc;
    logic             abort_req;
    logic [DIV_W:0]   div_gap;
    logic [DIV_W-1:0] div_next;

    sweep_dwell_timer #(
        .DURATION (DURATION)
    ) u_dwell_timer (
        .Sys_Clock (Sys_Clock),
        .Reset     (Reset),
        .clear     (state_q != ST_DWELL),
        .enable    (state_q == ST_DWELL),
        .tc        (dwell_tc)
    );

    assign transfer  = valid_q && cfg.Cfg_Ready;
    assign abort_req = abort_q || Abort;

    // Gap to the floor is taken one bit wider so the last step clamps to MIN instead of wrapping.
    assign div_gap  = {1'b0, cur_div_q} - MIN_X;
    assign div_next = (div_gap <= STEP_X) ? MIN_D : (cur_div_q - STEP_D);

    always_ff @(posedge Sys_Clock) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            cur_div_q  <= MAX_D;
            half_div_q <= DIS_D;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            step_q     <= '0;
        end else begin
            state_q    <= state_n;
            cur_div_q  <= cur_div_n;
            half_div_q <= half_div_n;
            valid_q    <= valid_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
            abort_q    <= abort_n;
            step_q     <= step_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        cur_div_n  = cur_div_q;
        half_div_n = half_div_q;
        valid_n    = valid_q;
        busy_n     = busy_q;
        done_n     = 1'b0;
        abort_n    = abort_q;
        step_n     = step_q;

        case (state_q)
            ST_IDLE: begin
                if (Start && !Abort) begin
                    state_n    = ST_LOAD;
                    cur_div_n  = MAX_D;
                    half_div_n = MAX_D;
                    valid_n    = 1'b1;
                    busy_n     = 1'b1;
                    abort_n    = 1'b0;
                    step_n     = '0;
                end
            end
            // An abort here only arms the latch; the offered divider stays put until accepted.
            ST_LOAD: begin
                abort_n = abort_req;
                if (transfer) begin
                    if (step_q != '1) begin
                        step_n = step_q + 1'b1;
                    end
                    if (abort_req) begin
                        state_n    = ST_SHUTDOWN;
                        half_div_n = DIS_D;
                    end else begin
                        state_n = ST_DWELL;
                        valid_n = 1'b0;
                    end
                end
            end
            ST_DWELL: begin
                if (abort_req) begin
                    abort_n    = 1'b1;
                    state_n    = ST_SHUTDOWN;
                    half_div_n = DIS_D;
                    valid_n    = 1'b1;
                end else if (dwell_tc) begin
                    valid_n = 1'b1;
                    if (cur_div_q == MIN_D) begin
                        state_n    = ST_SHUTDOWN;
                        half_div_n = DIS_D;
                    end else begin
                        state_n    = ST_LOAD;
                        cur_div_n  = div_next;
                        half_div_n = div_next;
                    end
                end
            end
            ST_SHUTDOWN: begin
                if (transfer) begin
                    valid_n = 1'b0;
                    busy_n  = 1'b0;
                    abort_n = 1'b0;
                    if (abort_q) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_DONE;
                        done_n  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
                valid_n = 1'b0;
                busy_n  = 1'b0;
                abort_n = 1'b0;
            end
        endcase
    end

    assign cfg.Cfg_Half_Div = half_div_q;
    assign cfg.Cfg_Valid    = valid_q;
    assign Sweep_Busy       = busy_q;
    assign Sweep_Done       = done_q;
    assign Step_Index       = step_q;

endmodule

// File: tb/tb_square_wave_sweep_ctrl.sv
// Directed bench for the sweep sequencer: a normal sweep, back-pressure, aborts,
// mid-sweep reset and a degenerate single-step instance.
module tb_square_wave_sweep_ctrl;

    logic       Sys_Clock;
    logic       Reset;
    logic       start_a, abort_a, ready_a;
    logic       start_b, abort_b, ready_b;
    logic       busy_a, done_a, busy_b, done_b;
    logic [7:0] step_a, step_b;

    int n_checks = 0;
    int n_errors = 0;
    int tb_cyc   = 0;
    int neg_cyc  = 0;

    logic [15:0] xfer_val_a[$];
    int          xfer_cyc_a[$];
    int          done_cnt_a;
    logic [15:0] xfer_val_b[$];
    int          done_cnt_b;

    square_wave_sweep_ctrl_if #(.DIV_W(16)) cfg_a ();
    square_wave_sweep_ctrl_if #(.DIV_W(16)) cfg_b ();

    assign cfg_a.Cfg_Ready = ready_a;
    assign cfg_b.Cfg_Ready = ready_b;

    square_wave_sweep_ctrl #(
        .DURATION(4), .MAX_HALF_DIV(20), .MIN_HALF_DIV(6), .DIV_STEP(5),
        .DISABLE_CODE(65535), .DIV_W(16)
    ) dut_a (
        .Sys_Clock(Sys_Clock), .Reset(Reset), .Start(start_a), .Abort(abort_a),
        .cfg(cfg_a), .Sweep_Busy(busy_a), .Sweep_Done(done_a), .Step_Index(step_a)
    );

    square_wave_sweep_ctrl #(
        .DURATION(4), .MAX_HALF_DIV(6), .MIN_HALF_DIV(6), .DIV_STEP(5),
        .DISABLE_CODE(65535), .DIV_W(16)
    ) dut_b (
        .Sys_Clock(Sys_Clock), .Reset(Reset), .Start(start_b), .Abort(abort_b),
        .cfg(cfg_b), .Sweep_Busy(busy_b), .Sweep_Done(done_b), .Step_Index(step_b)
    );

    initial begin
        Sys_Clock = 1'b0;
        forever #5 Sys_Clock = ~Sys_Clock;
    end

    // Transfers and done pulses are logged mid-cycle, ahead of the edge that takes them.
    always @(negedge Sys_Clock) begin
        neg_cyc++;
        if (Reset === 1'b0) begin
            if (cfg_a.Cfg_Valid === 1'b1 && ready_a === 1'b1) begin
                xfer_val_a.push_back(cfg_a.Cfg_Half_Div);
                xfer_cyc_a.push_back(neg_cyc);
            end
            if (done_a === 1'b1) done_cnt_a++;
            if (cfg_b.Cfg_Valid === 1'b1 && ready_b === 1'b1) xfer_val_b.push_back(cfg_b.Cfg_Half_Div);
            if (done_b === 1'b1) done_cnt_b++;
        end
    end

    task automatic tick();
        @(posedge Sys_Clock);
        #1;
        tb_cyc++;
    endtask

    task automatic clear_logs();
        xfer_val_a.delete();
        xfer_cyc_a.delete();
        xfer_val_b.delete();
        done_cnt_a = 0;
        done_cnt_b = 0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        n_checks++; if (cfg_a.Cfg_Half_Div !== 16'd65535) begin n_errors++; $display("FAIL reset_half_div: got %0d expected 65535", cfg_a.Cfg_Half_Div); end
        n_checks++; if (cfg_a.Cfg_Valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %0b expected 0", cfg_a.Cfg_Valid); end
        n_checks++; if (busy_a !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %0b expected 0", busy_a); end
        n_checks++; if (done_a !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %0b expected 0", done_a); end
        n_checks++; if (step_a !== 8'd0) begin n_errors++; $display("FAIL reset_step: got %0d expected 0", step_a); end
        n_checks++; if (cfg_b.Cfg_Half_Div !== 16'd65535) begin n_errors++; $display("FAIL reset_half_div_b: got %0d expected 65535", cfg_b.Cfg_Half_Div); end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_sweep();
        int  t0;
        int  len;
        bit  timed_out;
        int  exp_vals[5];
        exp_vals = '{20, 15, 10, 6, 65535};
        clear_logs();
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        t0 = tb_cyc;
        n_checks++; if (cfg_a.Cfg_Valid !== 1'b1) begin n_errors++; $display("FAIL basic_first_valid: got %0b expected 1", cfg_a.Cfg_Valid); end
        n_checks++; if (cfg_a.Cfg_Half_Div !== 16'd20) begin n_errors++; $display("FAIL basic_first_div: got %0d expected 20", cfg_a.Cfg_Half_Div); end
        n_checks++; if (busy_a !== 1'b1) begin n_errors++; $display("FAIL basic_busy: got %0b expected 1", busy_a); end
        timed_out = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (done_a === 1'b1) begin timed_out = 1'b0; break; end
        end
        len = tb_cyc - t0;
        n_checks++; if (timed_out) begin n_errors++; $display("FAIL basic_done_timeout: got no done expected done within 100 clks"); end
        n_checks++; if (len !== 21) begin n_errors++; $display("FAIL basic_length: got %0d expected 21", len); end
        n_checks++; if (step_a !== 8'd4) begin n_errors++; $display("FAIL basic_step: got %0d expected 4", step_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_errors++; $display("FAIL basic_busy_on_done: got %0b expected 0", busy_a); end
        n_checks++; if (xfer_val_a.size() !== 5) begin n_errors++; $display("FAIL basic_xfer_count: got %0d expected 5", xfer_val_a.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < xfer_val_a.size()) begin
                n_checks++; if (xfer_val_a[i] !== 16'(exp_vals[i])) begin n_errors++; $display("FAIL basic_xfer_val[%0d]: got %0d expected %0d", i, xfer_val_a[i], exp_vals[i]); end
            end
        end
        for (int i = 1; i < 5; i++) begin
            if (i < xfer_cyc_a.size()) begin
                n_checks++; if (xfer_cyc_a[i] - xfer_cyc_a[i-1] !== 5) begin n_errors++; $display("FAIL basic_spacing[%0d]: got %0d expected 5", i, xfer_cyc_a[i] - xfer_cyc_a[i-1]); end
            end
        end
        tick();
        n_checks++; if (done_a !== 1'b0) begin n_errors++; $display("FAIL basic_done_width: got %0b expected 0", done_a); end
        n_checks++; if (done_cnt_a !== 1) begin n_errors++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt_a); end
    endtask

    task automatic test_backpressure();
        int  t0;
        int  len;
        bit  timed_out;
        clear_logs();
        ready_a = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        t0 = tb_cyc;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (cfg_a.Cfg_Valid !== 1'b1) begin n_errors++; $display("FAIL bp_valid_held[%0d]: got %0b expected 1", k, cfg_a.Cfg_Valid); end
            n_checks++; if (cfg_a.Cfg_Half_Div !== 16'd20) begin n_errors++; $display("FAIL bp_div_held[%0d]: got %0d expected 20", k, cfg_a.Cfg_Half_Div); end
        end
        ready_a = 1'b1;
        timed_out = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (done_a === 1'b1) begin timed_out = 1'b0; break; end
        end
        len = tb_cyc - t0;
        n_checks++; if (timed_out) begin n_errors++; $display("FAIL bp_done_timeout: got no done expected done within 100 clks"); end
        n_checks++; if (len !== 24) begin n_errors++; $display("FAIL bp_length: got %0d expected 24", len); end
        n_checks++; if (xfer_val_a.size() !== 5) begin n_errors++; $display("FAIL bp_xfer_count: got %0d expected 5", xfer_val_a.size()); end
        if (xfer_cyc_a.size() >= 2) begin
            n_checks++; if (xfer_cyc_a[1] - xfer_cyc_a[0] !== 5) begin n_errors++; $display("FAIL bp_dwell_after_xfer: got %0d expected 5", xfer_cyc_a[1] - xfer_cyc_a[0]); end
        end
        tick();
    endtask

    task automatic test_abort_dwell();
        bit timed_out;
        clear_logs();
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        timed_out = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (xfer_val_a.size() == 2 && cfg_a.Cfg_Valid === 1'b0) begin timed_out = 1'b0; break; end
        end
        n_checks++; if (timed_out) begin n_errors++; $display("FAIL abd_reach_dwell: got timeout expected dwell on 15"); end
        tick();
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        n_checks++; if (cfg_a.Cfg_Valid !== 1'b1) begin n_errors++; $display("FAIL abd_valid: got %0b expected 1", cfg_a.Cfg_Valid); end
        n_checks++; if (cfg_a.Cfg_Half_Div !== 16'd65535) begin n_errors++; $display("FAIL abd_div: got %0d expected 65535", cfg_a.Cfg_Half_Div); end
        n_checks++; if (busy_a !== 1'b1) begin n_errors++; $display("FAIL abd_busy_shutdown: got %0b expected 1", busy_a); end
        tick();
        n_checks++; if (busy_a !== 1'b0) begin n_errors++; $display("FAIL abd_busy_after: got %0b expected 0", busy_a); end
        n_checks++; if (done_a !== 1'b0) begin n_errors++; $display("FAIL abd_done: got %0b expected 0", done_a); end
        n_checks++; if (step_a !== 8'd2) begin n_errors++; $display("FAIL abd_step: got %0d expected 2", step_a); end
        for (int i = 0; i < 5; i++) tick();
        n_checks++; if (done_cnt_a !== 0) begin n_errors++; $display("FAIL abd_done_count: got %0d expected 0", done_cnt_a); end
        n_checks++; if (xfer_val_a.size() !== 3) begin n_errors++; $display("FAIL abd_xfer_count: got %0d expected 3", xfer_val_a.size()); end
    endtask

    task automatic test_abort_load();
        bit timed_out;
        clear_logs();
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        timed_out = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (cfg_a.Cfg_Valid === 1'b1 && cfg_a.Cfg_Half_Div === 16'd10) begin timed_out = 1'b0; break; end
        end
        n_checks++; if (timed_out) begin n_errors++; $display("FAIL abl_reach_load: got timeout expected offer of 10"); end
        ready_a = 1'b0;
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (cfg_a.Cfg_Half_Div !== 16'd10 || cfg_a.Cfg_Valid !== 1'b1) begin n_errors++; $display("FAIL abl_held[%0d]: got div %0d valid %0b expected div 10 valid 1", k, cfg_a.Cfg_Half_Div, cfg_a.Cfg_Valid); end
            if (k < 2) tick();
        end
        ready_a = 1'b1;
        tick();
        n_checks++; if (cfg_a.Cfg_Half_Div !== 16'd65535) begin n_errors++; $display("FAIL abl_disable_div: got %0d expected 65535", cfg_a.Cfg_Half_Div); end
        n_checks++; if (step_a !== 8'd3) begin n_errors++; $display("FAIL abl_step: got %0d expected 3", step_a); end
        tick();
        n_checks++; if (busy_a !== 1'b0 || cfg_a.Cfg_Valid !== 1'b0) begin n_errors++; $display("FAIL abl_idle: got busy %0b valid %0b expected 0 0", busy_a, cfg_a.Cfg_Valid); end
        tick();
        n_checks++; if (done_cnt_a !== 0) begin n_errors++; $display("FAIL abl_done_count: got %0d expected 0", done_cnt_a); end
        n_checks++; if (xfer_val_a.size() !== 4) begin n_errors++; $display("FAIL abl_xfer_count: got %0d expected 4", xfer_val_a.size()); end
        if (xfer_val_a.size() == 4) begin
            n_checks++; if (xfer_val_a[2] !== 16'd10 || xfer_val_a[3] !== 16'd65535) begin n_errors++; $display("FAIL abl_xfer_tail: got %0d,%0d expected 10,65535", xfer_val_a[2], xfer_val_a[3]); end
        end
    endtask

    task automatic test_reset_mid_dwell();
        bit timed_out;
        bit saw_valid;
        clear_logs();
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        timed_out = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy_a === 1'b1 && cfg_a.Cfg_Valid === 1'b0) begin timed_out = 1'b0; break; end
        end
        n_checks++; if (timed_out) begin n_errors++; $display("FAIL rst_reach_dwell: got timeout expected dwell"); end
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        n_checks++; if (cfg_a.Cfg_Valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %0b expected 0", cfg_a.Cfg_Valid); end
        n_checks++; if (cfg_a.Cfg_Half_Div !== 16'd65535) begin n_errors++; $display("FAIL rst_div: got %0d expected 65535", cfg_a.Cfg_Half_Div); end
        n_checks++; if (busy_a !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %0b expected 0", busy_a); end
        n_checks++; if (step_a !== 8'd0) begin n_errors++; $display("FAIL rst_step: got %0d expected 0", step_a); end
        saw_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cfg_a.Cfg_Valid !== 1'b0) saw_valid = 1'b1;
        end
        n_checks++; if (saw_valid) begin n_errors++; $display("FAIL rst_no_offer: got offer expected none"); end
        n_checks++; if (xfer_val_a.size() !== 1) begin n_errors++; $display("FAIL rst_xfer_count: got %0d expected 1", xfer_val_a.size()); end
    endtask

    task automatic test_single_step();
        int t0;
        int len;
        bit timed_out;
        clear_logs();
        ready_b = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        t0 = tb_cyc;
        n_checks++; if (cfg_b.Cfg_Valid !== 1'b1 || cfg_b.Cfg_Half_Div !== 16'd6) begin n_errors++; $display("FAIL ss_first_offer: got valid %0b div %0d expected 1 6", cfg_b.Cfg_Valid, cfg_b.Cfg_Half_Div); end
        tick();
        tick();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        timed_out = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (done_b === 1'b1) begin timed_out = 1'b0; break; end
        end
        len = tb_cyc - t0;
        n_checks++; if (timed_out) begin n_errors++; $display("FAIL ss_done_timeout: got no done expected done within 50 clks"); end
        n_checks++; if (len !== 6) begin n_errors++; $display("FAIL ss_length: got %0d expected 6", len); end
        n_checks++; if (step_b !== 8'd1) begin n_errors++; $display("FAIL ss_step: got %0d expected 1", step_b); end
        n_checks++; if (xfer_val_b.size() !== 2) begin n_errors++; $display("FAIL ss_xfer_count: got %0d expected 2", xfer_val_b.size()); end
        if (xfer_val_b.size() == 2) begin
            n_checks++; if (xfer_val_b[0] !== 16'd6 || xfer_val_b[1] !== 16'd65535) begin n_errors++; $display("FAIL ss_xfer_vals: got %0d,%0d expected 6,65535", xfer_val_b[0], xfer_val_b[1]); end
        end
        for (int i = 0; i < 10; i++) tick();
        n_checks++; if (xfer_val_b.size() !== 2 || busy_b !== 1'b0) begin n_errors++; $display("FAIL ss_no_requeue: got xfers %0d busy %0b expected 2 0", xfer_val_b.size(), busy_b); end
        start_b = 1'b1;
        abort_b = 1'b1;
        tick();
        start_b = 1'b0;
        abort_b = 1'b0;
        n_checks++; if (cfg_b.Cfg_Valid !== 1'b0 || busy_b !== 1'b0) begin n_errors++; $display("FAIL ss_start_abort: got valid %0b busy %0b expected 0 0", cfg_b.Cfg_Valid, busy_b); end
        for (int i = 0; i < 5; i++) tick();
        n_checks++; if (xfer_val_b.size() !== 2) begin n_errors++; $display("FAIL ss_start_abort_xfers: got %0d expected 2", xfer_val_b.size()); end
        n_checks++; if (done_cnt_b !== 1) begin n_errors++; $display("FAIL ss_done_count: got %0d expected 1", done_cnt_b); end
    endtask

    initial begin
        Reset   = 1'b1;
        start_a = 1'b0;
        abort_a = 1'b0;
        ready_a = 1'b0;
        start_b = 1'b0;
        abort_b = 1'b0;
        ready_b = 1'b0;
        done_cnt_a = 0;
        done_cnt_b = 0;
        test_reset();
        test_basic_sweep();
        test_backpressure();
        test_abort_dwell();
        test_abort_load();
        test_reset_mid_dwell();
        test_single_step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
